// File: rtl/ddr2_word_packer_if.sv
// Sample-word input and DDR input-buffer signals for ddr2_word_packer.
// master drives words/flush/ib_re; slave is the packer.
interface ddr2_word_packer_if;
    logic        data_in_en;
    logic [15:0] data_in;
    logic        flush;
    logic        ib_re;
    logic [63:0] ib_data;
    logic [8:0]  ib_count;
    logic        ib_valid;
    logic        ib_empty;
    logic [1:0]  word_phase;
    logic        overflow;

    modport master (
        output data_in_en, data_in, flush, ib_re,
        input  ib_data, ib_count, ib_valid, ib_empty, word_phase, overflow
    );

    modport slave (
        input  data_in_en, data_in, flush, ib_re,
        output ib_data, ib_count, ib_valid, ib_empty, word_phase, overflow
    );
endinterface

// File: rtl/ddr2_word_packer.sv
// Packs four 16-bit words per 64-bit entry into a FIFO for the SDRAM FSM.
// Define PACKER_PAD_FLUSH_EN to zero-pad and push partial entries on flush.
module ddr2_word_packer #(
    parameter int DEPTH_LOG2 = 8
) (
    input logic clk,
    input logic reset,
    ddr2_word_packer_if.slave bus
);
    localparam int         DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [8:0] FULL_COUNT = 9'(DEPTH);

    logic [63:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [63:0]           pack;
    logic [63:0]           pack_next;
    logic [63:0]           stage;
    logic                  stage_valid;
    logic [1:0]            phase;
    logic [1:0]            phase_after;
    logic [8:0]            count;
    logic [63:0]           data_q;
    logic                  valid_q;
    logic                  overflow_q;
    logic                  word_done;
    logic                  flush_act;
    logic                  close;
    logic                  full;
    logic                  pop;
    logic                  push_ok;

    always_comb begin
        pack_next   = pack;
        phase_after = phase;
        if (bus.data_in_en) begin
            case (phase)
                2'd0:    pack_next[15:0]  = bus.data_in;
                2'd1:    pack_next[31:16] = bus.data_in;
                2'd2:    pack_next[47:32] = bus.data_in;
                default: pack_next[63:48] = bus.data_in;
            endcase
            phase_after = 2'(phase + 2'd1);
        end
    end

    // Word is taken first; flush then acts on whatever partial entry remains.
    assign word_done = bus.data_in_en && (phase == 2'd3);
    assign flush_act = bus.flush && !word_done && (phase_after != 2'd0);

`ifdef PACKER_PAD_FLUSH_EN
    assign close = word_done || flush_act;
`else
    assign close = word_done;
`endif

    assign full    = (count == FULL_COUNT);
    assign pop     = bus.ib_re && (count != 9'd0);
    assign push_ok = stage_valid && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pack        <= '0;
            phase       <= '0;
            stage       <= '0;
            stage_valid <= 1'b0;
        end else begin
            if (word_done || flush_act) begin
                pack  <= '0;
                phase <= '0;
            end else begin
                pack  <= pack_next;
                phase <= phase_after;
            end
            stage_valid <= close;
            if (close)
                stage <= pack_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= stage;
    end

    // A pop while full frees the slot the staged entry lands in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q <= pop;
            if (pop) begin
                data_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (stage_valid && !push_ok)
                overflow_q <= 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 9'd1;
                2'b01:   count <= count - 9'd1;
                default: count <= count;
            endcase
        end
    end

    assign bus.ib_data    = data_q;
    assign bus.ib_count   = count;
    assign bus.ib_valid   = valid_q;
    assign bus.ib_empty   = (count == 9'd0);
    assign bus.word_phase = phase;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_ddr2_word_packer.sv
// Scoreboard bench for ddr2_word_packer at DEPTH_LOG2=2.
// Reads push expected entries; a negedge monitor pops and compares.
module tb_ddr2_word_packer;
    logic clk = 1'b0;
    logic reset = 1'b1;

    ddr2_word_packer_if bus ();

    ddr2_word_packer #(.DEPTH_LOG2(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] expq[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (!reset && bus.ib_valid) begin
            if (expq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL ib_valid: got 1 with no read outstanding, expected 0");
            end else begin
                e = expq.pop_front();
                chk("ib_data", bus.ib_data, e);
            end
        end
    end

    function automatic logic [63:0] ent(input int k);
        logic [15:0] b;
        b = 16'(16'h1000 + k * 4);
        return {b + 16'd3, b + 16'd2, b + 16'd1, b};
    endfunction

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [15:0] w);
        bus.data_in_en = 1'b1;
        bus.data_in    = w;
        idle();
        bus.data_in_en = 1'b0;
    endtask

    task automatic push_entry(input int k);
        logic [63:0] e;
        e = ent(k);
        word(e[15:0]);
        word(e[31:16]);
        word(e[47:32]);
        word(e[63:48]);
    endtask

    task automatic rd(input logic [63:0] exp);
        expq.push_back(exp);
        bus.ib_re = 1'b1;
        idle();
        bus.ib_re = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
    endtask

    initial begin
        bus.data_in_en = 1'b0;
        bus.data_in    = '0;
        bus.flush      = 1'b0;
        bus.ib_re      = 1'b0;
        idle();
        idle();
        reset = 1'b0;

        chk("rst ib_data", bus.ib_data, 64'd0);
        chk("rst ib_count", 64'(bus.ib_count), 64'd0);
        chk("rst ib_valid", 64'(bus.ib_valid), 64'd0);
        chk("rst ib_empty", 64'(bus.ib_empty), 64'd1);
        chk("rst word_phase", 64'(bus.word_phase), 64'd0);
        chk("rst overflow", 64'(bus.overflow), 64'd0);

        // eight words -> two entries
        for (int i = 1; i <= 8; i++) word(16'(i));
        idle();
        chk("t1 ib_count", 64'(bus.ib_count), 64'd2);
        chk("t1 ib_empty", 64'(bus.ib_empty), 64'd0);
        rd(64'h0004_0003_0002_0001);
        idle();
        rd(64'h0008_0007_0006_0005);
        idle();
        chk("t1 drained", 64'(bus.ib_count), 64'd0);

        // overflow at depth 4
        for (int k = 0; k < 5; k++) push_entry(k);
        idle();
        chk("t2 ib_count", 64'(bus.ib_count), 64'd4);
        chk("t2 overflow", 64'(bus.overflow), 64'd1);
        for (int k = 0; k < 4; k++) rd(ent(k));
        idle();
        chk("t2 drained", 64'(bus.ib_count), 64'd0);
        chk("t2 sticky", 64'(bus.overflow), 64'd1);

        // push and pop together while full, pointers wrap
        do_reset();
        chk("t3 ovf cleared", 64'(bus.overflow), 64'd0);
        for (int k = 0; k < 4; k++) push_entry(k);
        idle();
        chk("t3 full", 64'(bus.ib_count), 64'd4);
        for (int k = 4; k < 8; k++) begin
            push_entry(k);
            rd(ent(k - 4));
            chk("t3 count pair", 64'(bus.ib_count), 64'd4);
        end
        chk("t3 overflow", 64'(bus.overflow), 64'd0);
        for (int k = 4; k < 8; k++) rd(ent(k));
        idle();
        chk("t3 drained", 64'(bus.ib_count), 64'd0);

        // flush of a three-word partial entry
        word(16'hAAAA);
        word(16'hBBBB);
        word(16'hCCCC);
        chk("t4 phase3", 64'(bus.word_phase), 64'd3);
        bus.flush = 1'b1;
        idle();
        bus.flush = 1'b0;
        chk("t4 phase0", 64'(bus.word_phase), 64'd0);
        idle();
`ifdef PACKER_PAD_FLUSH_EN
        chk("t4 count", 64'(bus.ib_count), 64'd1);
        rd(64'h0000_CCCC_BBBB_AAAA);
        idle();
`else
        chk("t4 count", 64'(bus.ib_count), 64'd0);
`endif
        bus.flush = 1'b1;
        idle();
        bus.flush = 1'b0;
        idle();
        chk("t4 flush idle", 64'(bus.ib_count), 64'd0);

        // read while empty
        bus.ib_re = 1'b1;
        idle();
        bus.ib_re = 1'b0;
        chk("t5 ib_valid", 64'(bus.ib_valid), 64'd0);
        chk("t5 ib_count", 64'(bus.ib_count), 64'd0);
        idle();

        // asynchronous reset mid-word
        for (int k = 0; k < 3; k++) push_entry(k);
        word(16'h7777);
        word(16'h8888);
        chk("t6 pre phase", 64'(bus.word_phase), 64'd2);
        chk("t6 pre count", 64'(bus.ib_count), 64'd3);
        #2 reset = 1'b1;
        #1;
        chk("t6 ib_count", 64'(bus.ib_count), 64'd0);
        chk("t6 word_phase", 64'(bus.word_phase), 64'd0);
        chk("t6 ib_empty", 64'(bus.ib_empty), 64'd1);
        chk("t6 ib_data", bus.ib_data, 64'd0);
        chk("t6 ib_valid", 64'(bus.ib_valid), 64'd0);
        idle();
        reset = 1'b0;
        word(16'h5A01);
        word(16'h5A02);
        word(16'h5A03);
        word(16'h5A04);
        idle();
        chk("t6 fresh count", 64'(bus.ib_count), 64'd1);
        rd(64'h5A04_5A03_5A02_5A01);

        repeat (3) idle();
        chk("pending reads", 64'(expq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
